// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Transaction FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // funct3 access-size codes.
    localparam logic [2:0] SizeB  = 3'b000;
    localparam logic [2:0] SizeH  = 3'b001;
    localparam logic [2:0] SizeW  = 3'b010;
    localparam logic [2:0] SizeBu = 3'b100;
    localparam logic [2:0] SizeHu = 3'b101;

    // Per-byte write enable for one 32-bit word.
    typedef logic [3:0] be_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and store replication, plus load
// extraction and sign/zero extension, from the funct3 size and addr[1:0].
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned H/HU/W accesses fault instead
// of being forced to natural alignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output be_t         be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        fault
);

    logic [1:0]  eff_lo;
    logic        size_ok;
    logic [31:0] rsh;

    // Decode size into effective lane offset, byte enables and replicated store data.
    always_comb begin
        eff_lo   = addr_lo;
        size_ok  = 1'b1;
        be       = '0;
        wdata_sh = wdata;
        case (size)
            SizeB, SizeBu: begin
                be       = be_t'(4'b0001 << addr_lo);
                wdata_sh = {4{wdata[7:0]}};
            end
            SizeH, SizeHu: begin
                eff_lo   = {addr_lo[1], 1'b0};
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
            end
            SizeW: begin
                eff_lo = 2'b00;
                be     = 4'b1111;
            end
            default: size_ok = 1'b0;
        endcase
    end

    assign rsh = rword >> {eff_lo, 3'b000};

    // Extract the addressed lane and extend it to 32 bits.
    always_comb begin
        rdata = '0;
        case (size)
            SizeB:   rdata = {{24{rsh[7]}}, rsh[7:0]};
            SizeBu:  rdata = {24'h0, rsh[7:0]};
            SizeH:   rdata = {{16{rsh[15]}}, rsh[15:0]};
            SizeHu:  rdata = {16'h0, rsh[15:0]};
            SizeW:   rdata = rword;
            default: rdata = '0;
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic misaligned;
    assign misaligned = ((size == SizeH || size == SizeHu) && addr_lo[0]) ||
                        (size == SizeW && addr_lo != 2'b00);
    assign fault = ~size_ok | misaligned;
`else
    assign fault = ~size_ok;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Misalignment handling is selected by DMEM_MISALIGN_ERR_EN (see dmem_lane_align).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CntInit   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fire;

    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        cur_we;
    logic [2:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata, cur_off;
    logic        in_range, lane_fault, txn_err;
    logic [IdxW-1:0] idx;
    be_t         be;
    logic [31:0] wdata_sh, ld_data;

    // With zero latency the access completes on the accepting edge, so the live
    // request is used directly while idle; otherwise the latched copy is used.
    assign cur_we    = (state_q == StIdle) ? req_we    : we_q;
    assign cur_size  = (state_q == StIdle) ? req_size  : size_q;
    assign cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;

    // Below-base addresses wrap to large offsets and fail the range check.
    assign cur_off  = cur_addr - BASE_ADDR;
    assign in_range = {1'b0, cur_off} < SpanBytes;
    assign idx      = in_range ? cur_off[IdxW+1:2] : '0;
    assign txn_err  = ~in_range | lane_fault;

    dmem_lane_align u_lane_align (
        .size     (cur_size),
        .addr_lo  (cur_addr[1:0]),
        .wdata    (cur_wdata),
        .rword    (mem[idx]),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (ld_data),
        .fault    (lane_fault)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; fire marks the edge that performs the memory access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = StResp;
                        fire    = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Request capture on acceptance and response capture on the access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (req_valid && state_q == StIdle) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (fire) begin
                err_q   <= txn_err;
                rdata_q <= (cur_we || txn_err) ? 32'h0 : ld_data;
            end
        end
    end

    // Byte-enabled store; storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (fire && rst_n && cur_we && !txn_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a byte-level reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned TRACK = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mbytes [TRACK];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes_of(input logic [2:0] s);
        case (s)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_fault(input logic [2:0] s, input logic [31:0] a);
        int nb;
        logic [31:0] off;
        nb  = nbytes_of(s);
        off = a - BASE;
        if (nb == 0) return 1'b1;
        if (off >= 32'(4 * DEPTH)) return 1'b1;
`ifdef DMEM_MISALIGN_ERR_EN
        if ((a % nb) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] a);
        int nb;
        logic [31:0] off, base_off, v;
        if (model_fault(s, a)) return 32'h0;
        nb       = nbytes_of(s);
        off      = a - BASE;
        base_off = off - (off % nb);
        v        = 0;
        for (int k = 0; k < nb; k++) v = v | (32'(mbytes[base_off + k]) << (8 * k));
        if (s == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (s == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [2:0] s, input logic [31:0] a, input logic [31:0] wd);
        int nb;
        logic [31:0] off, base_off;
        if (model_fault(s, a)) return;
        nb       = nbytes_of(s);
        off      = a - BASE;
        base_off = off - (off % nb);
        for (int k = 0; k < nb; k++)
            if (base_off + k < TRACK) mbytes[base_off + k] = wd[8*k +: 8];
    endtask

    // ---------------- bus driver (no checking) ----------------
    // lat: negedges from the accepting edge until rsp_valid is seen (40 = timeout).
    // stable: response held during backpressure with req_ready low, and
    // req_ready/rsp_valid back to 1/0 in the cycle after consumption.
    task automatic txn(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat,
                       output bit stable);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        // Scramble the request bus: the accepted transaction must be unaffected.
        req_valid = 1'b0;
        req_we    = ~we;
        req_size  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) break;
        end
        rd     = rsp_rdata;
        er     = rsp_err;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0)
                stable = 1'b0;
        end
        if (req_ready !== 1'b0) stable = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) stable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init_region;
        logic [31:0] rd, wd;
        logic er;
        int lat;
        bit st;
        for (int w = 0; w < TRACK / 4; w++) begin
            wd = $urandom;
            txn(1'b1, 3'b010, BASE + 32'(4 * w), wd, 0, rd, er, lat, st);
            model_store(3'b010, BASE + 32'(4 * w), wd);
        end
    endtask

    task automatic test_directed;
        logic        t_we [9];
        logic [2:0]  t_sz [9];
        logic [31:0] t_ad [9];
        logic [31:0] t_wd [9];
        logic [31:0] t_ex [9];
        logic [31:0] rd;
        logic er;
        int lat;
        bit st;
        t_we = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        t_sz = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b001};
        t_ad = '{32'h8000_0010, 32'h8000_0010, 32'h8000_0013, 32'h8000_0013, 32'h8000_0012,
                 32'h8000_0012, 32'h8000_0011, 32'h8000_0010, 32'h8000_0010};
        t_wd = '{32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0000_0055, 0, 0};
        t_ex = '{32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD,
                 32'h0000_DEAD, 32'h0, 32'hDEAD_55EF, 32'h0000_55EF};
        for (int i = 0; i < 9; i++) begin
            txn(t_we[i], t_sz[i], t_ad[i], t_wd[i], 0, rd, er, lat, st);
            if (t_we[i]) model_store(t_sz[i], t_ad[i], t_wd[i]);
            n_cmp++;
            if (rd !== t_ex[i] || er !== 1'b0) begin
                n_bad++;
                $display("FAIL directed[%0d]: rdata=%h err=%b, want %h 0", i, rd, er, t_ex[i]);
            end
            n_cmp++;
            if (lat !== LAT + 1) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %0d cycles, want %0d", i, lat, LAT + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        logic er;
        int lat;
        bit st;
        txn(1'b0, 3'b010, 32'h8000_0010, 0, 5, rd, er, lat, st);
        n_cmp++;
        if (st !== 1'b1 || rd !== 32'hDEAD_55EF) begin
            n_bad++;
            $display("FAIL backpressure: stable=%b rdata=%h, want 1 dead55ef", st, rd);
        end
    endtask

    task automatic test_range;
        logic        t_we [6];
        logic [2:0]  t_sz [6];
        logic [31:0] t_ad [6];
        logic [31:0] rd;
        logic er;
        int lat;
        bit st;
        t_we = '{0, 1, 1, 0, 1, 0};
        t_sz = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b111, 3'b110};
        t_ad = '{32'h7FFF_FFFC, BASE + 32'(4 * DEPTH), 32'h7FFF_FFFC, 32'h8000_0010,
                 32'h8000_0010, 32'h8000_0010};
        for (int i = 0; i < 6; i++) begin
            txn(t_we[i], t_sz[i], t_ad[i], 32'h1111_2222, 0, rd, er, lat, st);
            n_cmp++;
            if (er !== 1'b1 || rd !== 32'h0) begin
                n_bad++;
                $display("FAIL range[%0d]: err=%b rdata=%h, want 1 00000000", i, er, rd);
            end
        end
        txn(1'b0, 3'b010, 32'h8000_0010, 0, 0, rd, er, lat, st);
        n_cmp++;
        if (rd !== 32'hDEAD_55EF || er !== 1'b0) begin
            n_bad++;
            $display("FAIL range_unchanged: rdata=%h err=%b, want dead55ef 0", rd, er);
        end
        // Last in-range word.
        txn(1'b1, 3'b010, BASE + 32'(4 * DEPTH - 4), 32'hA5A5_0F0F, 0, rd, er, lat, st);
        txn(1'b0, 3'b000, BASE + 32'(4 * DEPTH - 1), 0, 0, rd, er, lat, st);
        n_cmp++;
        if (rd !== 32'hFFFF_FFA5 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL top_word: rdata=%h err=%b, want ffffffa5 0", rd, er);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] rd, ex;
        logic er, ex_er;
        int lat;
        bit st;
`ifdef DMEM_MISALIGN_ERR_EN
        ex = 32'h0;
        ex_er = 1'b1;
`else
        ex = 32'hDEAD_55EF;
        ex_er = 1'b0;
`endif
        txn(1'b0, 3'b010, 32'h8000_0012, 0, 0, rd, er, lat, st);
        n_cmp++;
        if (rd !== ex || er !== ex_er) begin
            n_bad++;
            $display("FAIL misalign: rdata=%h err=%b, want %h %b", rd, er, ex, ex_er);
        end
    endtask

    task automatic test_random;
        logic [2:0]  sizes [8];
        logic [2:0]  sz;
        logic [31:0] a, wd, rd, ex;
        logic we, er, ex_er;
        int lat;
        bit st;
        sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            sz = sizes[$urandom_range(0, 7)];
            a  = BASE + 32'($urandom_range(0, TRACK - 1));
            wd = $urandom;
            ex    = we ? 32'h0 : model_load(sz, a);
            ex_er = model_fault(sz, a);
            txn(we, sz, a, wd, $urandom_range(0, 3), rd, er, lat, st);
            if (we) model_store(sz, a, wd);
            n_cmp++;
            if (rd !== ex || er !== ex_er || lat !== LAT + 1 || st !== 1'b1) begin
                n_bad++;
                $display("FAIL random[%0d] we=%b sz=%b a=%h: rdata=%h err=%b lat=%0d st=%b, want %h %b %0d 1",
                         i, we, sz, a, rd, er, lat, st, ex, ex_er, LAT + 1);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd, ex;
        logic er;
        int lat;
        bit st;
        ex = model_load(3'b010, 32'h8000_0020);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 3'b010;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_abort_outputs: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 3'b010, 32'h8000_0020, 0, 0, rd, er, lat, st);
        n_cmp++;
        if (rd !== ex || er !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort_mem: rdata=%h err=%b, want %h 0", rd, er, ex);
        end
    endtask

    initial begin
        test_reset();
        test_init_region();
        test_directed();
        test_backpressure();
        test_range();
        test_misalign();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit storage words.
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response (0..15).
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000, byte address mapped to word 0.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  core presents a load/store request.
REQ-007 req_ready  out  1  responder accepts a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  core consumes response.
REQ-014 rsp_rdata  out  32  load data, aligned and extended; 0 for stores and errors.
REQ-015 rsp_err  out  1  request faulted; no memory update.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready SHALL equal (state==IDLE).
REQ-017 Acceptance: req_valid && req_ready at a rising edge latches we/size/addr/wdata; IDLE->WAIT, or IDLE->RESP when LATENCY==0.
REQ-018 WAIT counts LATENCY cycles; rsp_valid SHALL rise exactly LATENCY+1 cycles after the accepting edge.
REQ-019 Store write SHALL occur on the WAIT->RESP (or IDLE->RESP) edge, byte-enabled per size and addr[1:0].
REQ-020 Load data SHALL be read on the same edge: B/H sign-extended, BU/HU zero-extended, W unchanged, lane selected by addr[1:0].
REQ-021 In RESP, rsp_valid and all response outputs SHALL hold stable until rsp_ready; rsp_valid && rsp_ready -> IDLE.
REQ-022 No new request accepted in the cycle the response is consumed; earliest next acceptance is one cycle later.
REQ-023 Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) or unsupported size code: rsp_err=1, rsp_rdata=0, no write.
REQ-024 Offset arithmetic 32-bit unsigned; addresses below BASE_ADDR wrap high and fall out of range.
REQ-025 req_valid deasserted mid-transaction has no effect on the accepted transaction.

Reset
REQ-026 rst_n low SHALL force state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 on exit.
REQ-027 Reset asserted during WAIT SHALL abort the transaction; a pending store SHALL NOT be written.
REQ-028 Storage contents not cleared by reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_ERR_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL return rsp_err=1, rsp_rdata=0, no write.
REQ-030 Macro undefined: misaligned low bits SHALL be cleared to natural alignment and access completes normally, rsp_err only from REQ-023.

Structure
REQ-031 Package dmem_pkg holds the state enum, funct3 size localparams and byte-enable type.
REQ-032 One sub-module dmem_lane_align: combinational byte-enable/store-shift and load extract/extend from size and addr[1:0].
REQ-033 FSM, counter, storage array and response registers in dmem_responder.

Verification
REQ-034 SW 0xDEADBEEF @0x8000_0010, then LW @0x8000_0010 -> rsp_rdata=0xDEADBEEF, rsp_valid at cycle 3 after each acceptance (LATENCY=2).
REQ-035 After REQ-034, LB @0x8000_0013 -> 0xFFFFFFDE; LBU -> 0x000000DE; LH @0x8000_0012 -> 0xFFFFDEAD; SB 0x55 @0x8000_0011 then LW -> 0xDEAD55EF.
REQ-036 Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata stable, req_ready=0 throughout; req_ready=1 one cycle after consumption.
REQ-037 LW @0x7FFF_FFFC and SW @BASE_ADDR+4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-038 LW @0x8000_0012: with DMEM_MISALIGN_ERR_EN -> rsp_err=1; without -> rsp_rdata=word @0x8000_0010, rsp_err=0.
REQ-039 Assert rst_n=0 one cycle after accepting SW 0x12345678 @0x8000_0020 -> outputs reset immediately, later LW returns prior contents.
